// File: rtl/seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// seq_det_scheduler
//
// Time-shares one external serial sequence detector among NREQ requesters.
// A request is picked round-robin, the detector is cleared with a one-cycle
// reset pulse, the FRAME_W-bit frame is shifted into the detector LSB-first,
// and the number of cycles with det_y=1 is returned with the requester ID.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_ready is a combinational one-hot grant, offered only in
// IDLE and never speculatively held. rsp_valid stays high, with rsp_id and
// rsp_count frozen, until the cycle in which rsp_ready is 1.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   req_valid  [NREQ]          per-requester request pending
//   req_data   [NREQ*FRAME_W]  frame of requester i at [i*FRAME_W +: FRAME_W]
//   req_ready  [NREQ]          one-hot accept (combinational)
//   rsp_valid                  result available
//   rsp_ready                  consumer accepts result
//   rsp_id     [ID_W]          index of the served requester
//   rsp_count  [CNT_W]         number of det_y=1 cycles in the frame
//   rsp_first  [CNT_W]         (SEQ_SCHED_FIRST_HIT_EN only) SHIFT-cycle index
//                              of the first det_y=1, FRAME_W if none
//   det_c                      detector serial input C
//   det_rst_n                  detector reset, active-low
//   det_y                      detector output Y
//
// Optional build macro: SEQ_SCHED_FIRST_HIT_EN adds the rsp_first port.
// -----------------------------------------------------------------------------
module seq_det_scheduler #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*FRAME_W-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CNT_W-1:0]        rsp_count,
`ifdef SEQ_SCHED_FIRST_HIT_EN
  output logic [CNT_W-1:0]        rsp_first,
`endif
  output logic                    det_c,
  output logic                    det_rst_n,
  input  logic                    det_y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]    last_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   idx_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  logic [CNT_W-1:0]   first_q;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter.
  // The request vector is doubled and a window of NREQ bits starting at
  // last+1 is taken, so bit k of req_rot is requester (last+1+k) mod NREQ.
  // The lowest set bit of req_rot is the winner.
  // ---------------------------------------------------------------------------
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [ID_W:0]     rot_base;
  logic [ID_W-1:0]   rot_off;
  logic [ID_W:0]     grant_sum;
  logic [ID_W-1:0]   grant;
  logic              any_req;
  logic              last_bit;

  assign req_dbl  = {req_valid, req_valid};
  assign rot_base = {1'b0, last_q} + (ID_W+1)'(1);
  assign any_req  = |req_valid;

  // rot_base is in 1..NREQ, so only those window positions are needed.
  always_comb begin
    req_rot = req_valid;
    for (int s = 1; s <= NREQ; s++) begin
      if (rot_base == (ID_W+1)'(s)) begin
        req_rot = req_dbl[s +: NREQ];
      end
    end
  end

  // Descending scan so the lowest set offset is the one left in rot_off.
  always_comb begin
    rot_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rot_off = ID_W'(k);
      end
    end
  end

  // last+1+offset is at most 2*NREQ-1, so one conditional subtract wraps it.
  assign grant_sum = rot_base + {1'b0, rot_off};
  assign grant     = (grant_sum >= (ID_W+1)'(NREQ))
                     ? ID_W'(grant_sum - (ID_W+1)'(NREQ))
                     : grant_sum[ID_W-1:0];

  assign last_bit = (idx_q == CNT_W'(FRAME_W - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    det_c     = 1'b0;
    // The detector is held in reset during CLEAR and whenever we are reset.
    det_rst_n = rst & (state != CLEAR);

    case (state)
      IDLE: begin
        // Gating with rst keeps req_ready low while reset is asserted.
        if (any_req && rst) begin
          req_ready = NREQ'(1) << grant;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        det_c = shreg_q[0];
        if (last_bit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= ID_W'(NREQ - 1);
      shreg_q <= '0;
      id_q    <= '0;
      count_q <= '0;
      idx_q   <= '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
      first_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            shreg_q <= req_data[int'(grant)*FRAME_W +: FRAME_W];
            id_q    <= grant;
            last_q  <= grant;
            count_q <= '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
            // FRAME_W doubles as the "no hit yet" marker.
            first_q <= CNT_W'(FRAME_W);
`endif
          end
        end
        CLEAR: begin
          idx_q <= '0;
        end
        SHIFT: begin
          // det_y belongs to the bit currently on det_c.
          count_q <= count_q + {{(CNT_W-1){1'b0}}, det_y};
          shreg_q <= shreg_q >> 1;
          idx_q   <= idx_q + CNT_W'(1);
`ifdef SEQ_SCHED_FIRST_HIT_EN
          if (det_y && (first_q == CNT_W'(FRAME_W))) begin
            first_q <= idx_q;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_id    = id_q;
  assign rsp_count = count_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  assign rsp_first = first_q;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_det_scheduler
//
// Directed bench for seq_det_scheduler. Contains a behavioural model of the
// external 4-state Mealy detector, and a linear sequence of directed steps
// with hand-computed expected counts.
//
// Detector model (state, C -> next, Y):
//   S0: 0->S0 y0, 1->S1 y0
//   S1: 0->S2 y0, 1->S1 y0
//   S2: 0->S2 y1, 1->S3 y1
//   S3: 0->S0 y0, 1->S0 y1
// Frames (LSB first) and hand-derived results:
//   8'h01 -> count 6, first 2     8'h05 -> count 1, first 2
//   8'h0D -> count 2, first 2     8'h00 / 8'hFF -> count 0, first 8
// -----------------------------------------------------------------------------
module tb_seq_det_scheduler;

  localparam int NREQ    = 4;
  localparam int FRAME_W = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*FRAME_W-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [CNT_W-1:0]        rsp_count;
`ifdef SEQ_SCHED_FIRST_HIT_EN
  logic [CNT_W-1:0]        rsp_first;
`endif
  logic                    det_c;
  logic                    det_rst_n;
  logic                    det_y;

  int n_checks;
  int n_errors;

  // Scoreboard queues for streamed traffic.
  int               exp_grant_q[$];
  logic [ID_W-1:0]  exp_id_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  logic [CNT_W-1:0] exp_first_q[$];
  logic [CNT_W-1:0] cnt_tab[NREQ];
  logic [CNT_W-1:0] first_tab[NREQ];

  seq_det_scheduler #(
    .NREQ    (NREQ),
    .FRAME_W (FRAME_W),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
`ifdef SEQ_SCHED_FIRST_HIT_EN
    .rsp_first (rsp_first),
`endif
    .det_c     (det_c),
    .det_rst_n (det_rst_n),
    .det_y     (det_y)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // External detector model
  // ---------------------------------------------------------------------------
  logic [1:0] det_s;
  logic [1:0] det_s_nxt;

  always_comb begin
    det_s_nxt = det_s;
    det_y     = 1'b0;
    case (det_s)
      2'd0: if (det_c) det_s_nxt = 2'd1;
      2'd1: if (!det_c) det_s_nxt = 2'd2;
      2'd2: begin
        det_y = 1'b1;
        if (det_c) det_s_nxt = 2'd3;
      end
      default: begin
        det_y     = det_c;
        det_s_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) det_s <= 2'd0;
    else            det_s <= det_s_nxt;
  end

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Inputs change on the falling edge; outputs are sampled
  // #1 after that, half a period away from the active edge.
  // ---------------------------------------------------------------------------
  task automatic set_frame(input int r, input logic [FRAME_W-1:0] d);
    req_data[r*FRAME_W +: FRAME_W] = d;
  endtask

  // Present a request from r alone and wait for the grant.
  task automatic request_one(input string tag, input int r);
    @(negedge clk);
    req_valid = NREQ'(1) << r;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != '0) break;
      @(negedge clk);
      #1;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(1) << r);
  endtask

  // Called right after the grant was seen; drops req_valid after accept and
  // checks response latency and contents.
  task automatic wait_rsp(input string tag, input logic [ID_W-1:0] id,
                          input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] fst);
    int lat;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = '0;
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(10));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_count"}, 32'(rsp_count), 32'(cnt));
`ifdef SEQ_SCHED_FIRST_HIT_EN
    check({tag, "_first"}, 32'(rsp_first), 32'(fst));
`endif
  endtask

  task automatic single_frame(input string tag, input int r, input logic [FRAME_W-1:0] d,
                              input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] fst);
    rsp_ready = 1'b1;
    set_frame(r, d);
    request_one(tag, r);
    wait_rsp(tag, ID_W'(r), cnt, fst);
    @(negedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'(0));
  endtask

  // Streamed traffic with rsp_ready tied high: checks grant order against
  // exp_grant_q, spacing between accepts, and every response.
  task automatic run_stream(input string tag, input int n_frames, input logic [NREQ-1:0] mask);
    int  grants;
    int  resps;
    int  last_g;
    bit  drop;
    grants = 0;
    resps  = 0;
    last_g = 0;
    drop   = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = mask;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (drop) begin
          req_valid = '0;
          drop = 1'b0;
        end
      end
      #1;
      if (req_ready != '0) begin
        int g;
        g = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 0;
        check({tag, "_grant"}, 32'(req_ready), 32'(1) << g);
        if (grants > 0) check({tag, "_gap"}, 32'(cyc - last_g), 32'(FRAME_W + 3));
        last_g = cyc;
        grants++;
        exp_id_q.push_back(ID_W'(g));
        exp_cnt_q.push_back(cnt_tab[g]);
        exp_first_q.push_back(first_tab[g]);
        if (grants == n_frames) drop = 1'b1;
      end
      if (rsp_valid) begin
        logic [ID_W-1:0]  e_id;
        logic [CNT_W-1:0] e_cnt;
        logic [CNT_W-1:0] e_fst;
        e_id  = (exp_id_q.size() > 0) ? exp_id_q.pop_front() : '1;
        e_cnt = (exp_cnt_q.size() > 0) ? exp_cnt_q.pop_front() : '1;
        e_fst = (exp_first_q.size() > 0) ? exp_first_q.pop_front() : '1;
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(e_id));
        check({tag, "_rsp_count"}, 32'(rsp_count), 32'(e_cnt));
`ifdef SEQ_SCHED_FIRST_HIT_EN
        check({tag, "_rsp_first"}, 32'(rsp_first), 32'(e_fst));
`endif
        resps++;
        if (resps == n_frames) break;
      end
    end
    check({tag, "_responses"}, 32'(resps), 32'(n_frames));
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    req_valid = '1;
    req_data  = {8'hFF, 8'h0D, 8'h05, 8'h01};
    rsp_ready = 1'b0;

    // Reset state, with requests pending to show req_ready is suppressed.
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    check("rst_rsp_count", 32'(rsp_count), 32'(0));
    check("rst_det_c", 32'(det_c), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_det_rst_n", 32'(det_rst_n), 32'(0));
`ifdef SEQ_SCHED_FIRST_HIT_EN
    check("rst_rsp_first", 32'(rsp_first), 32'(0));
`endif
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b1;
    #1;
    check("post_rst_det_rst_n", 32'(det_rst_n), 32'(1));
    check("post_rst_req_ready", 32'(req_ready), 32'(0));

    // Single frame from requester 2.
    single_frame("f01_r2", 2, 8'h01, 4'd6, 4'd2);

    // Frame isolation on requester 0.
    single_frame("f05_r0", 0, 8'h05, 4'd1, 4'd2);
    single_frame("f0d_r0", 0, 8'h0D, 4'd2, 4'd2);
    single_frame("f00_r0", 0, 8'h00, 4'd0, 4'd8);
    single_frame("fff_r0", 0, 8'hFF, 4'd0, 4'd8);

    // Back-pressure: response held while rsp_ready is low, no grants offered.
    rsp_ready = 1'b0;
    set_frame(3, 8'h0D);
    request_one("hold", 3);
    wait_rsp("hold", 2'd3, 4'd2, 4'd2);
    set_frame(0, 8'h00);
    req_valid = 4'b0001;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_id", 32'(rsp_id), 32'(3));
      check("hold_count", 32'(rsp_count), 32'(2));
      check("hold_req_ready", 32'(req_ready), 32'(0));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("hold_release_valid", 32'(rsp_valid), 32'(1));
    @(negedge clk);
    #1;
    check("after_hold_valid", 32'(rsp_valid), 32'(0));
    check("after_hold_grant", 32'(req_ready), 32'(4'b0001));
    wait_rsp("after_hold", 2'd0, 4'd0, 4'd8);

    // Reset during the 4th SHIFT cycle of a frame from requester 1.
    set_frame(1, 8'hFF);
    request_one("midrst", 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = '0;
    end
    #1;
    check("midrst_det_c_before", 32'(det_c), 32'(1));
    check("midrst_det_rst_n_before", 32'(det_rst_n), 32'(1));
    #1;
    rst = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("midrst_det_rst_n", 32'(det_rst_n), 32'(0));
    check("midrst_det_c", 32'(det_c), 32'(0));
    check("midrst_rsp_id", 32'(rsp_id), 32'(0));
    req_data  = {8'hFF, 8'h0D, 8'hFF, 8'h05};
    req_valid = 4'b1111;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_release_grant", 32'(req_ready), 32'(4'b0001));
    wait_rsp("midrst_next", 2'd0, 4'd1, 4'd2);
    @(negedge clk);

    // Round robin with all four requesters pending, from a fresh reset.
    apply_reset();
    req_data     = {8'hFF, 8'h0D, 8'h05, 8'h01};
    cnt_tab[0]   = 4'd6;  first_tab[0] = 4'd2;
    cnt_tab[1]   = 4'd1;  first_tab[1] = 4'd2;
    cnt_tab[2]   = 4'd2;  first_tab[2] = 4'd2;
    cnt_tab[3]   = 4'd0;  first_tab[3] = 4'd8;
    exp_grant_q  = '{0, 1, 2, 3, 0};
    run_stream("rr", 5, 4'b1111);

    // Back-to-back requests on requester 1.
    set_frame(1, 8'h0D);
    cnt_tab[1]   = 4'd2;
    first_tab[1] = 4'd2;
    exp_grant_q  = '{1, 1, 1};
    run_stream("b2b", 3, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
